// File: rtl/mem_pkg.sv
// Shared encodings for the data memory: access sizes, controller states, word width.
// Combinational helper only; no latency, no backpressure.
package mem_pkg;

    localparam int WORD_W = 32;

    typedef enum logic [1:0] {
        SZ_BYTE = 2'b00,
        SZ_HALF = 2'b01,
        SZ_WORD = 2'b10,
        SZ_RSVD = 2'b11
    } size_e;

    typedef enum logic [1:0] {
        ST_IDLE   = 2'b00,
        ST_WAIT   = 2'b01,
        ST_ACCESS = 2'b10,
        ST_RESP   = 2'b11
    } state_e;

    // Natural-alignment and reserved-size fault for one access.
    function automatic logic access_fault(input logic [1:0] size, input logic [1:0] lane);
        logic fault;
        case (size)
            SZ_BYTE: fault = 1'b0;
            SZ_HALF: fault = lane[0];
            SZ_WORD: fault = (lane != 2'b00);
            default: fault = 1'b1;
        endcase
        return fault;
    endfunction

endpackage

// File: rtl/lane_align.sv
// Little-endian lane merge for stores and lane extract/extend for loads.
// Purely combinational; no backpressure.
module lane_align
    import mem_pkg::*;
(
    input  logic [WORD_W-1:0] old_word,
    input  logic [WORD_W-1:0] wdata,
    input  logic [1:0]        size,
    input  logic [1:0]        offset,
    input  logic              sign_ext,
    output logic [WORD_W-1:0] merged,
    output logic [WORD_W-1:0] load_val
);

    logic [4:0]        byte_sh;
    logic [4:0]        half_sh;
    logic [WORD_W-1:0] byte_src;
    logic [15:0]       half_src;

    assign byte_sh  = {offset, 3'b000};
    assign half_sh  = {offset[1], 4'b0000};
    assign byte_src = old_word >> byte_sh;
    assign half_src = offset[1] ? old_word[31:16] : old_word[15:0];

    always_comb begin
        merged   = old_word;
        load_val = '0;
        case (size)
            SZ_BYTE: begin
                merged   = (old_word & ~(32'h0000_00FF << byte_sh))
                         | ({24'd0, wdata[7:0]} << byte_sh);
                load_val = {{24{sign_ext & byte_src[7]}}, byte_src[7:0]};
            end
            SZ_HALF: begin
                merged   = (old_word & ~(32'h0000_FFFF << half_sh))
                         | ({16'd0, wdata[15:0]} << half_sh);
                load_val = {{16{sign_ext & half_src[15]}}, half_src};
            end
            SZ_WORD: begin
                merged   = wdata;
                load_val = old_word;
            end
            default: begin
                merged   = old_word;
                load_val = '0;
            end
        endcase
    end

endmodule

// File: rtl/data_mem_ctrl.sv
// Data memory with req/ack handshake and byte/half/word access; DM_WRITE_LOG_EN adds a store log.
// Latency: ack in the cycle after edge accept+LATENCY+1; one request in flight.
// Backpressure: busy from accept through the ack cycle; req is ignored while busy.
module data_mem_ctrl
    import mem_pkg::*;
#(
    parameter int          DEPTH_WORDS = 1024,
    parameter int          LATENCY     = 1,
    parameter logic [31:0] BASE_ADDR   = 32'h0000_0000
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              req,
    input  logic              we,
    input  logic [1:0]        size,
    input  logic              sign_ext,
    input  logic [WORD_W-1:0] addr,
    input  logic [WORD_W-1:0] wdata,
    input  logic [WORD_W-1:0] pc,
    output logic              busy,
    output logic              ack,
    output logic              err,
    output logic [WORD_W-1:0] rdata
);

    localparam int          IDX_W    = (DEPTH_WORDS > 1) ? $clog2(DEPTH_WORDS) : 1;
    localparam logic [32:0] END_ADDR = {1'b0, BASE_ADDR} + 33'(DEPTH_WORDS) * 33'd4;

    state_e            state_q, state_d;
    logic [3:0]        cnt_q, cnt_d;
    logic              busy_q, busy_d;
    logic              ack_q, ack_d;
    logic              err_q, err_d;
    logic [WORD_W-1:0] rdata_q, rdata_d;
    logic              we_q, we_d;
    logic [1:0]        size_q, size_d;
    logic              sext_q, sext_d;
    logic [WORD_W-1:0] addr_q, addr_d;
    logic [WORD_W-1:0] wdata_q, wdata_d;
    logic [WORD_W-1:0] pc_q, pc_d;

    logic [WORD_W-1:0] mem_q [DEPTH_WORDS];

    logic [WORD_W-1:0] offset;
    logic [IDX_W-1:0]  idx;
    logic              in_range;
    logic              acc_err;
    logic              mem_we;
    logic [WORD_W-1:0] old_word;
    logic [WORD_W-1:0] merged;
    logic [WORD_W-1:0] load_val;
    logic              unused_offset;

    // Unsigned compare against both ends catches addresses that wrap below the base.
    assign offset        = addr_q - BASE_ADDR;
    assign idx           = offset[IDX_W+1:2];
    assign in_range      = (addr_q >= BASE_ADDR) && ({1'b0, addr_q} < END_ADDR);
    assign acc_err       = access_fault(size_q, addr_q[1:0]) || !in_range;
    assign old_word      = mem_q[idx];
    assign unused_offset = ^{offset[WORD_W-1:IDX_W+2], offset[1:0]};

    lane_align u_lane_align (
        .old_word (old_word),
        .wdata    (wdata_q),
        .size     (size_q),
        .offset   (addr_q[1:0]),
        .sign_ext (sext_q),
        .merged   (merged),
        .load_val (load_val)
    );

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        busy_d  = busy_q;
        ack_d   = 1'b0;
        err_d   = err_q;
        rdata_d = rdata_q;
        we_d    = we_q;
        size_d  = size_q;
        sext_d  = sext_q;
        addr_d  = addr_q;
        wdata_d = wdata_q;
        pc_d    = pc_q;
        mem_we  = 1'b0;
        case (state_q)
            ST_IDLE: begin
                if (req) begin
                    we_d    = we;
                    size_d  = size;
                    sext_d  = sign_ext;
                    addr_d  = addr;
                    wdata_d = wdata;
                    pc_d    = pc;
                    cnt_d   = 4'(LATENCY);
                    busy_d  = 1'b1;
                    state_d = (LATENCY == 0) ? ST_ACCESS : ST_WAIT;
                end
            end
            ST_WAIT: begin
                cnt_d = cnt_q - 4'd1;
                if (cnt_q == 4'd1) begin
                    state_d = ST_ACCESS;
                end
            end
            ST_ACCESS: begin
                ack_d   = 1'b1;
                err_d   = acc_err;
                rdata_d = (acc_err || we_q) ? '0 : load_val;
                mem_we  = we_q && !acc_err;
                state_d = ST_RESP;
            end
            ST_RESP: begin
                busy_d  = 1'b0;
                state_d = ST_IDLE;
            end
            default: state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= ST_IDLE;
            cnt_q   <= '0;
            busy_q  <= 1'b0;
            ack_q   <= 1'b0;
            err_q   <= 1'b0;
            rdata_q <= '0;
            we_q    <= 1'b0;
            size_q  <= '0;
            sext_q  <= 1'b0;
            addr_q  <= '0;
            wdata_q <= '0;
            pc_q    <= '0;
            for (int i = 0; i < DEPTH_WORDS; i++) begin
                mem_q[i] <= '0;
            end
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            busy_q  <= busy_d;
            ack_q   <= ack_d;
            err_q   <= err_d;
            rdata_q <= rdata_d;
            we_q    <= we_d;
            size_q  <= size_d;
            sext_q  <= sext_d;
            addr_q  <= addr_d;
            wdata_q <= wdata_d;
            pc_q    <= pc_d;
            if (mem_we) begin
                mem_q[idx] <= merged;
            end
        end
    end

`ifdef DM_WRITE_LOG_EN
    always_ff @(posedge clk) begin
        if (!reset && mem_we) begin
            $display("%d@%h: *%h <= %h", $time, pc_q, {addr_q[WORD_W-1:2], 2'b00}, merged);
        end
    end
`else
    logic unused_pc;
    assign unused_pc = ^pc_q;
`endif

    assign busy  = busy_q;
    assign ack   = ack_q;
    assign err   = err_q;
    assign rdata = rdata_q;

endmodule
